// File: rtl/nvdla_done_intr_gen_pkg.sv
// Shared types and constants for the layer-done interrupt generator.
// Holds the default outstanding-write counter width, the pending-entry layout,
// the pending FIFO depth and the register-group encoding.
package nvdla_done_intr_gen_pkg;

    localparam int OS_CNT_W_DEF = 8;
    localparam int PEND_DEPTH   = 2;

    typedef enum logic {
        GRP0 = 1'b0,
        GRP1 = 1'b1
    } grp_e;

    // Default-width view of one pending entry: group plus writes still in flight.
    typedef struct packed {
        grp_e                    grp;
        logic [OS_CNT_W_DEF-1:0] rem_cnt;
    } pend_ent_t;

endpackage

// File: rtl/nvdla_done_pend_fifo.sv
// Two-entry in-order FIFO of ended layers awaiting write drain.
// Latency: push/pop/decrement take effect at the next clock; head/second counts are registered.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
// Ports: clk_i/rst_n_i, push_i/push_grp_i/push_cnt_i, pop_i, dec_head_i/dec_sec_i,
//        head_vld_o/head_grp_o/head_cnt_o, sec_vld_o/sec_cnt_o, occ_o.
module nvdla_done_pend_fifo
    import nvdla_done_intr_gen_pkg::*;
#(
    parameter int W = OS_CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  grp_e         push_grp_i,
    input  logic [W-1:0] push_cnt_i,
    input  logic         pop_i,
    input  logic         dec_head_i,
    input  logic         dec_sec_i,
    output logic         head_vld_o,
    output grp_e         head_grp_o,
    output logic [W-1:0] head_cnt_o,
    output logic         sec_vld_o,
    output logic [W-1:0] sec_cnt_o,
    output logic [1:0]   occ_o
);

    typedef struct packed {
        grp_e         grp;
        logic [W-1:0] rem_cnt;
    } ent_t;

    ent_t ent0_q, ent0_d, ent1_q, ent1_d, push_ent;
    logic vld0_q, vld0_d, vld1_q, vld1_d;

    assign push_ent = '{grp: push_grp_i, rem_cnt: push_cnt_i};

    // Entries are kept compacted: entry1 valid implies entry0 valid.
    // Decrements apply before the shift so a response owned by entry1
    // is not lost when the head pops in the same cycle.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        if (dec_head_i) ent0_d.rem_cnt = ent0_q.rem_cnt - W'(1);
        if (dec_sec_i)  ent1_d.rem_cnt = ent1_q.rem_cnt - W'(1);
        if (pop_i) begin
            ent0_d = ent1_d;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end
        if (push_i) begin
            if (!vld0_d) begin
                ent0_d = push_ent;
                vld0_d = 1'b1;
            end else begin
                ent1_d = push_ent;
                vld1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
        end
    end

    assign head_vld_o = vld0_q;
    assign head_grp_o = ent0_q.grp;
    assign head_cnt_o = ent0_q.rem_cnt;
    assign sec_vld_o  = vld1_q;
    assign sec_cnt_o  = ent1_q.rem_cnt;
    assign occ_o      = {vld0_q & vld1_q, vld0_q ^ vld1_q};

endmodule

// File: rtl/nvdla_done_intr_gen.sv
// Layer-done interrupt source: pulses done_intr_pd[grp] once every write of an ended layer has a response.
// Latency: draining response at cycle N -> pulse at N+1; zero-outstanding layer end at N -> pulse at N+2.
// Backpressure: none; overflow/underflow/saturation set sticky intr_err. Optional NVDLA_DONE_INTR_DBG_CNT_EN adds done_cnt0/1.
module nvdla_done_intr_gen
    import nvdla_done_intr_gen_pkg::*;
#(
    parameter int OS_CNT_W = OS_CNT_W_DEF
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        layer_end_vld,
    input  logic        layer_end_grp,
    input  logic        dma_wr_accept,
    input  logic        dma_wr_rsp,
    input  logic        err_clr,
    output logic [1:0]  done_intr_pd,
    output logic [1:0]  pending_cnt,
    output logic        intr_err
`ifdef NVDLA_DONE_INTR_DBG_CNT_EN
    ,
    output logic [15:0] done_cnt0,
    output logic [15:0] done_cnt1
`endif
);

    logic [OS_CNT_W-1:0] cur_q, cur_d, cur_next;
    logic [1:0]          pulse_q, pulse_d;
    logic                err_q, err_d;

    logic                head_vld, sec_vld;
    grp_e                head_grp;
    logic [OS_CNT_W-1:0] head_cnt, sec_cnt;
    logic [1:0]          occ;

    logic rsp_head, rsp_sec, rsp_cur, underflow, sat, pop, push, overflow;

    // Responses belong to the oldest owner still waiting on writes.
    assign rsp_head  = dma_wr_rsp && head_vld && (head_cnt != '0);
    assign rsp_sec   = dma_wr_rsp && !rsp_head && sec_vld && (sec_cnt != '0);
    assign rsp_cur   = dma_wr_rsp && !rsp_head && !rsp_sec && (cur_q != '0);
    assign underflow = dma_wr_rsp && !rsp_head && !rsp_sec && !rsp_cur;

    assign sat      = dma_wr_accept && !rsp_cur && (cur_q == '1);
    assign cur_next = sat ? cur_q : cur_q + OS_CNT_W'(dma_wr_accept) - OS_CNT_W'(rsp_cur);

    assign pop      = head_vld && ((head_cnt == '0) || ((head_cnt == OS_CNT_W'(1)) && rsp_head));
    // A same-cycle pop frees a slot, so a full FIFO can still take the push.
    assign push     = layer_end_vld && (!sec_vld || pop);
    assign overflow = layer_end_vld && sec_vld && !pop;

    // The ending layer's snapshot already carries this cycle's accept, so the live counter restarts at zero.
    assign cur_d   = layer_end_vld ? '0 : cur_next;
    assign pulse_d = !pop ? 2'b00 : (head_grp == GRP1) ? 2'b10 : 2'b01;
    assign err_d   = (underflow || sat || overflow) ? 1'b1 : (err_clr ? 1'b0 : err_q);

    nvdla_done_pend_fifo #(.W(OS_CNT_W)) u_pend_fifo (
        .clk_i      (nvdla_core_clk),
        .rst_n_i    (nvdla_core_rstn),
        .push_i     (push),
        .push_grp_i (grp_e'(layer_end_grp)),
        .push_cnt_i (cur_next),
        .pop_i      (pop),
        .dec_head_i (rsp_head),
        .dec_sec_i  (rsp_sec),
        .head_vld_o (head_vld),
        .head_grp_o (head_grp),
        .head_cnt_o (head_cnt),
        .sec_vld_o  (sec_vld),
        .sec_cnt_o  (sec_cnt),
        .occ_o      (occ)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cur_q   <= '0;
            pulse_q <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign done_intr_pd = pulse_q;
    assign pending_cnt  = occ;
    assign intr_err     = err_q;

`ifdef NVDLA_DONE_INTR_DBG_CNT_EN
    logic [15:0] dcnt0_q, dcnt0_d, dcnt1_q, dcnt1_d;

    // Counters advance on the same edge the pulse appears; clear has priority.
    always_comb begin
        dcnt0_d = dcnt0_q;
        dcnt1_d = dcnt1_q;
        if (err_clr) begin
            dcnt0_d = '0;
            dcnt1_d = '0;
        end else begin
            if (pulse_d[0] && (dcnt0_q != 16'hFFFF)) dcnt0_d = dcnt0_q + 16'd1;
            if (pulse_d[1] && (dcnt1_q != 16'hFFFF)) dcnt1_d = dcnt1_q + 16'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dcnt0_q <= '0;
            dcnt1_q <= '0;
        end else begin
            dcnt0_q <= dcnt0_d;
            dcnt1_q <= dcnt1_d;
        end
    end

    assign done_cnt0 = dcnt0_q;
    assign done_cnt1 = dcnt1_q;
`else
    // Debug pulse counters are not built.
`endif

endmodule
